npu_mm_engine: RTL and testbench
================================

NPU_MM_ENGINE -- requirements
Module: npu_mm_engine

Interface
REQ-001 The block SHALL be parameterised as listed in REQ-002 to REQ-004.
REQ-002 Parameter DW, default 32, sets the data word width in bits; it also sets the width of all products and sums.
REQ-003 Parameter N, default 3, range 2..8, sets the systolic array dimension; the block computes an N x N by N x N matrix product.
REQ-004 Parameter DEPTH, default 64, sets the number of words in local memory; AW = clog2(DEPTH) is derived from it.
REQ-005 The block SHALL have the ports listed in REQ-006 to REQ-021.
REQ-006 clk, input, 1: the single clock for the whole block.
REQ-007 rst, input, 1: reset, asynchronous and active-low.
REQ-008 start, input, 1: command strobe.
REQ-009 src1_addr, input, AW: base word address of A, stored row-major.
REQ-010 src2_addr, input, AW: base word address of B, stored row-major.
REQ-011 rd_addr, input, AW: base word address of C, stored row-major.
REQ-012 acc_mode, input, 1: when high, the result is C = C_old + A*B.
REQ-013 relu_mode, input, 1: when high, negative results are clamped to 0 before write.
REQ-014 busy, output, 1: a command is in progress.
REQ-015 done, output, 1: one-cycle completion pulse.
REQ-016 err, output, 1: one-cycle pulse when a command is rejected.
REQ-017 mem_we, input, 1: host write strobe.
REQ-018 mem_re, input, 1: host read strobe.
REQ-019 mem_addr, input, AW: host word address.
REQ-020 mem_wd, input, DW: host write data.
REQ-021 mem_rd, output, DW: host read data, registered.

Function
REQ-022 Local memory SHALL be a DEPTH x DW register array, shared between the host port and the engine.
REQ-023 Host port behaviour SHALL be:
- mem_we writes mem_wd to mem_addr at the clock edge.
- mem_re returns the addressed word on mem_rd one cycle later.
- When mem_we and mem_re are both high, the write wins and mem_rd is 0 the next cycle.
- When neither is high, mem_rd is 0.
REQ-024 While busy is high, host writes SHALL be dropped and mem_rd SHALL be 0.
REQ-025 The FSM SHALL have states IDLE, COMPUTE, WRITEBACK and DONE.
REQ-026 In IDLE, start SHALL be sampled. If src1_addr, src2_addr or rd_addr + N*N - 1 >= DEPTH, the block pulses err for one cycle and stays in IDLE. Otherwise it latches all command inputs and enters COMPUTE.
REQ-027 start SHALL be ignored in any state other than IDLE; inputs latched at start SHALL not change for the rest of the command.
REQ-028 COMPUTE SHALL last exactly 3N-2 cycles, t = 0..3N-3, and SHALL clear all PE accumulators on entry.
REQ-029 During COMPUTE, row i of the array SHALL receive A[i][t-i] and column j SHALL receive B[t-j][j] when 0 <= t-i < N (respectively 0 <= t-j < N), and 0 otherwise.
REQ-030 Each PE(i,j) SHALL forward its a operand right and its b operand down with one register stage, and SHALL accumulate a*b.
REQ-031 WRITEBACK SHALL last N*N cycles and write one word per cycle in row-major order, idx = i*N + j, to address rd_addr + idx.
REQ-032 The value written in WRITEBACK SHALL be computed as follows:
- v = acc(i,j), plus mem[rd_addr + idx] when acc_mode is high.
- If relu_mode is high and v is negative, v is replaced by 0.
REQ-033 All arithmetic SHALL be two's-complement signed; products and sums SHALL be truncated to DW bits with wrap-around and no saturation.
REQ-034 Overlap between the source regions and the rd region SHALL be legal, because sources are fully consumed before WRITEBACK starts.
REQ-035 DONE SHALL last one cycle with done high, then return to IDLE.
REQ-036 busy SHALL be high exactly in COMPUTE and WRITEBACK.
REQ-037 done SHALL occur 3N-2+N*N cycles after busy rises, which is 16 cycles for N=3.
REQ-038 start may be held high; a new command SHALL begin only in an IDLE cycle, so back-to-back commands have one IDLE cycle between them.

Reset
REQ-039 While rst is low, the following SHALL hold:
- FSM is in IDLE.
- busy, done, err and mem_rd are 0.
- All PE accumulators and operand pipeline registers are 0.
REQ-040 Local memory contents SHALL not be reset.
REQ-041 Asserting rst mid-command SHALL abort the command; words already written in WRITEBACK SHALL remain and the rest stay unchanged.
REQ-042 After rst deasserts, the first start SHALL be accepted on the first clock edge.

Verification (N=3, DW=32, DEPTH=64)
REQ-043 The bench SHALL cover the scenarios in REQ-044 to REQ-049.
REQ-044 Identity test:
- Stimulus: A = 1..9 at address 0, B = identity at address 9, start with rd_addr = 18.
- Response: busy high for 16 cycles, done pulse, then mem[18..26] = 1..9.
REQ-045 Accumulate with ReLU:
- Stimulus: mem[18..26] preloaded to 100; A = all -1 at address 0, B = all 50 at address 9; acc_mode = 1 and relu_mode = 1.
- Response: each element is -150 + 100 = -50, which ReLU clamps to 0, so all nine words read back 0.
REQ-046 Range reject:
- Stimulus: start with rd_addr = 56.
- Response: err pulses for exactly one cycle, busy stays 0, memory is unchanged.
REQ-047 Host access while busy:
- Stimulus: mem_we to address 40 with data 0xDEAD, issued during COMPUTE.
- Response: mem[40] is unchanged; mem_rd is 0 while busy.
REQ-048 Reset mid-command:
- Stimulus: rst pulled low in WRITEBACK after 4 words have been written.
- Response: mem[18..21] are updated, mem[22..26] are old values, and all outputs are 0 immediately (asynchronous reset).
REQ-049 Wrap-around and timing:
- Stimulus: A = all 0x7FFFFFFF, B = all 2.
- Response: each product is 0xFFFFFFFE and each element is 0xFFFFFFFA (-6); start held high gives back-to-back commands with exactly one IDLE cycle between done and the next busy.

Source files
------------

// File: rtl/npu_mm_engine.sv
// N x N output-stationary systolic matrix-multiply engine with a shared register-file memory.
// A host port owns the memory when idle; a command computes C = [C_old +] A*B with optional ReLU.
module npu_mm_engine #(
  parameter int  DW    = 32,
  parameter int  N     = 3,
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src1_addr,
  input  logic [AW-1:0] src2_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic          acc_mode,
  input  logic          relu_mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          mem_we,
  input  logic          mem_re,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wd,
  output logic [DW-1:0] mem_rd
);

  localparam int CW = $clog2(N * N + 3 * N);

  typedef enum logic [1:0] {StIdle, StCompute, StWriteback, StDone} state_e;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_src1, r_src2, r_rd;
  logic          r_acc_mode, r_relu, r_busy, r_done, r_err;
  logic [DW-1:0] r_mem_rd;
  logic [DW-1:0] r_mem [DEPTH];
  // The rightmost column / bottom row would forward into nothing, so those stages are omitted.
  logic [DW-1:0] r_a   [N][N-1];
  logic [DW-1:0] r_b   [N-1][N];
  logic [DW-1:0] r_acc [N][N];
  logic [DW-1:0] w_a_in [N];
  logic [DW-1:0] w_b_in [N];
  logic [DW-1:0] w_pa [N][N];
  logic [DW-1:0] w_pb [N][N];
  logic [DW-1:0] w_acc_sel, w_wb_val;
  logic [AW-1:0] w_wb_addr;
  logic          w_range_err, w_accept;

  assign w_range_err = (32'(src1_addr) + 32'(N * N - 1) >= 32'(DEPTH)) ||
                       (32'(src2_addr) + 32'(N * N - 1) >= 32'(DEPTH)) ||
                       (32'(rd_addr)   + 32'(N * N - 1) >= 32'(DEPTH));
  assign w_accept = (r_state == StIdle) && start && !w_range_err;

  // Skewed edge feed: row i sees A[i][t-i], column j sees B[t-j][j].
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_in[i] = '0;
      w_b_in[i] = '0;
      if (r_state == StCompute && r_cnt >= CW'(i) && r_cnt < CW'(i + N)) begin
        w_a_in[i] = r_mem[r_src1 + AW'(i * N) + AW'(r_cnt - CW'(i))];
        w_b_in[i] = r_mem[r_src2 + AW'((r_cnt - CW'(i)) * N) + AW'(i)];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_pa[i][0] = w_a_in[i];
      w_pb[0][i] = w_b_in[i];
      for (int j = 1; j < N; j++) begin
        w_pa[i][j] = r_a[i][j-1];
        w_pb[j][i] = r_b[j-1][i];
      end
    end
  end

  always_comb begin
    w_acc_sel = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (r_cnt == CW'(i * N + j)) w_acc_sel = r_acc[i][j];
      end
    end
    w_wb_addr = r_rd + AW'(r_cnt);
    w_wb_val  = w_acc_sel + (r_acc_mode ? r_mem[w_wb_addr] : '0);
    if (r_relu && w_wb_val[DW-1]) w_wb_val = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_rd       <= '0;
      r_acc_mode <= 1'b0;
      r_relu     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_mem_rd   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_busy || w_accept || mem_we || !mem_re) r_mem_rd <= '0;
      else                                         r_mem_rd <= r_mem[mem_addr];
      unique case (r_state)
        StIdle: begin
          if (start && w_range_err) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_src1     <= src1_addr;
            r_src2     <= src2_addr;
            r_rd       <= rd_addr;
            r_acc_mode <= acc_mode;
            r_relu     <= relu_mode;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= StCompute;
          end
        end
        StCompute: begin
          if (r_cnt == CW'(3 * N - 3)) begin
            r_cnt   <= '0;
            r_state <= StWriteback;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWriteback: begin
          if (r_cnt == CW'(N * N - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) r_acc[i][j] <= '0;
        for (int j = 0; j < N - 1; j++) r_a[i][j] <= '0;
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) r_b[i][j] <= '0;
      end
    end else if (w_accept || r_state == StCompute) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= w_accept ? '0 : r_acc[i][j] + w_pa[i][j] * w_pb[i][j];
        end
        for (int j = 0; j < N - 1; j++) r_a[i][j] <= w_accept ? '0 : w_pa[i][j];
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) r_b[i][j] <= w_accept ? '0 : w_pb[i][j];
      end
    end
  end

  // Memory contents survive reset; the engine owns the write port during writeback.
  always_ff @(posedge clk) begin
    if (r_state == StWriteback)   r_mem[w_wb_addr] <= w_wb_val;
    else if (mem_we && !r_busy)   r_mem[mem_addr]  <= mem_wd;
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign mem_rd = r_mem_rd;

endmodule

// File: tb/tb_npu_mm_engine.sv
// Directed self-checking bench for npu_mm_engine (N=3, DW=32, DEPTH=64).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_npu_mm_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  src1_addr = '0, src2_addr = '0, rd_addr = '0;
  logic        acc_mode = 1'b0, relu_mode = 1'b0;
  logic        busy, done, err;
  logic        mem_we = 1'b0, mem_re = 1'b0;
  logic [5:0]  mem_addr = '0;
  logic [31:0] mem_wd = '0;
  logic [31:0] mem_rd;

  int n_checks = 0;
  int n_pass   = 0;

  // A = 1..9 times B = 9..1, row-major.
  logic [31:0] prod_exp [9] = '{32'd30, 32'd24, 32'd18, 32'd84, 32'd69, 32'd54,
                                32'd138, 32'd114, 32'd90};

  npu_mm_engine #(.DW(32), .N(3), .DEPTH(64)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src1_addr (src1_addr),
    .src2_addr (src2_addr),
    .rd_addr   (rd_addr),
    .acc_mode  (acc_mode),
    .relu_mode (relu_mode),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = 6'(a); mem_wd = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic host_rd(input int a, output logic [31:0] d);
    mem_re = 1'b1; mem_addr = 6'(a);
    @(negedge clk);
    d = mem_rd;
    mem_re = 1'b0;
  endtask

  task automatic set_cmd(input int s1, input int s2, input int rd, input logic acc,
                         input logic relu);
    src1_addr = 6'(s1); src2_addr = 6'(s2); rd_addr = 6'(rd);
    acc_mode = acc; relu_mode = relu;
  endtask

  task automatic count_busy(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Issues one command and returns busy length and whether done followed it.
  task automatic run_cmd(input int s1, input int s2, input int rd, input logic acc,
                         input logic relu, output int cyc, output logic dn);
    set_cmd(s1, s2, rd, acc, relu);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_busy(cyc);
    dn = done;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rv;
    int          cyc;
    int          gap;
    logic        dn;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_rd", mem_rd, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous write and read: write wins, read data is zero.
    host_wr(41, 32'h1111);
    mem_we = 1'b1; mem_re = 1'b1; mem_addr = 6'd41; mem_wd = 32'h77;
    @(negedge clk);
    mem_we = 1'b0; mem_re = 1'b0;
    check("we_re_rd_zero", mem_rd, 32'd0);
    host_rd(41, rv);
    check("we_re_write_won", rv, 32'h77);
    @(negedge clk);
    check("no_strobe_rd_zero", mem_rd, 32'd0);

    // Identity: C = A * I.
    for (int k = 0; k < 9; k++) host_wr(k, 32'(k + 1));
    for (int k = 0; k < 9; k++) host_wr(9 + k, (k % 4 == 0) ? 32'd1 : 32'd0);
    for (int k = 0; k < 9; k++) host_wr(18 + k, 32'hAA);
    run_cmd(0, 9, 18, 1'b0, 1'b0, cyc, dn);
    check("id_busy_cycles", 32'(cyc), 32'd16);
    check("id_done", 32'(dn), 32'd1);
    check("id_done_one_cycle", 32'(done), 32'd0);
    for (int k = 0; k < 9; k++) begin
      host_rd(18 + k, rv);
      check($sformatf("id_c%0d", k), rv, 32'(k + 1));
    end

    // General product with a different destination.
    for (int k = 0; k < 9; k++) host_wr(9 + k, 32'(9 - k));
    run_cmd(0, 9, 30, 1'b0, 1'b0, cyc, dn);
    check("prod_busy_cycles", 32'(cyc), 32'd16);
    for (int k = 0; k < 9; k++) begin
      host_rd(30 + k, rv);
      check($sformatf("prod_c%0d", k), rv, prod_exp[k]);
    end

    // Accumulate without and with ReLU: -150 + 100 = -50.
    for (int k = 0; k < 9; k++) host_wr(k, 32'hFFFF_FFFF);
    for (int k = 0; k < 9; k++) host_wr(9 + k, 32'd50);
    for (int k = 0; k < 9; k++) host_wr(18 + k, 32'd100);
    run_cmd(0, 9, 18, 1'b1, 1'b0, cyc, dn);
    for (int k = 0; k < 9; k++) begin
      host_rd(18 + k, rv);
      check($sformatf("acc_c%0d", k), rv, 32'hFFFF_FFCE);
    end
    for (int k = 0; k < 9; k++) host_wr(18 + k, 32'd100);
    run_cmd(0, 9, 18, 1'b1, 1'b1, cyc, dn);
    check("relu_done", 32'(dn), 32'd1);
    for (int k = 0; k < 9; k++) begin
      host_rd(18 + k, rv);
      check($sformatf("relu_c%0d", k), rv, 32'd0);
    end

    // Range reject on rd_addr and src1_addr; rd_addr 55 is the last legal base.
    host_wr(56, 32'h5555);
    set_cmd(0, 9, 56, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rej_err", 32'(err), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rej_err_pulse", 32'(err), 32'd0);
    check("rej_busy_after", 32'(busy), 32'd0);
    host_rd(56, rv);
    check("rej_mem_kept", rv, 32'h5555);
    set_cmd(56, 9, 18, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rej_src1_err", 32'(err), 32'd1);
    @(negedge clk);
    run_cmd(0, 9, 55, 1'b0, 1'b0, cyc, dn);
    check("edge_rd55_busy", 32'(cyc), 32'd16);

    // Host access while busy is dropped and reads return zero.
    host_wr(40, 32'h1234);
    set_cmd(0, 9, 18, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mem_we = 1'b1; mem_addr = 6'd40; mem_wd = 32'hDEAD;
    @(negedge clk);
    mem_we = 1'b0; mem_re = 1'b1;
    @(negedge clk);
    mem_re = 1'b0;
    check("busy_rd_zero", mem_rd, 32'd0);
    cyc = 0;
    while (!done && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_cmd_done", 32'(done), 32'd1);
    @(negedge clk);
    host_rd(40, rv);
    check("busy_wr_dropped", rv, 32'h1234);

    // Reset after four writeback words.
    for (int k = 0; k < 9; k++) host_wr(k, 32'(k + 1));
    for (int k = 0; k < 9; k++) host_wr(9 + k, (k % 4 == 0) ? 32'd1 : 32'd0);
    for (int k = 0; k < 9; k++) host_wr(18 + k, 32'(32'hB0 + k));
    set_cmd(0, 9, 18, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_mem_rd", mem_rd, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      host_rd(18 + k, rv);
      check($sformatf("mid_c%0d", k), rv, (k < 4) ? 32'(k + 1) : 32'(32'hB0 + k));
    end

    // Wrap-around with start held high across two commands, starting right out of reset.
    for (int k = 0; k < 9; k++) host_wr(k, 32'h7FFF_FFFF);
    for (int k = 0; k < 9; k++) host_wr(9 + k, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    set_cmd(0, 9, 18, 1'b0, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("first_edge_accept", 32'(busy), 32'd1);
    count_busy(cyc);
    check("b2b_busy1", 32'(cyc), 32'd16);
    check("b2b_done1", 32'(done), 32'd1);
    @(negedge clk);
    gap = 0;
    while (!busy && gap < 5) begin
      gap++;
      @(negedge clk);
    end
    check("b2b_idle_gap", 32'(gap), 32'd1);
    start = 1'b0;
    count_busy(cyc);
    check("b2b_busy2", 32'(cyc), 32'd16);
    check("b2b_done2", 32'(done), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      host_rd(18 + k, rv);
      check($sformatf("wrap_c%0d", k), rv, 32'hFFFF_FFFA);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
